// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, reads instruction memory and buffers
// {instr, pc+4} pairs in a small circular queue that drains into decode.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [6:0]  imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_next_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [63:0]   entry_reg [DEPTH];

    logic [31:0] pc_plus4;
    logic        pop;
    logic        push;
    logic        wr_en;
    logic [63:0] head;

    assign pc_plus4  = fetch_pc_reg + 32'd4;
    assign out_valid = (count_reg != '0);
    assign pop       = out_valid & ~stall;
    assign push      = (count_reg < CW'(DEPTH)) | pop;
    // Storage is written only on a normal push; reset and redirect leave stale data behind the pointers.
    assign wr_en     = push & ~RST & ~redirect_valid;

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        if (redirect_valid) begin
            fetch_pc_next = redirect_pc;
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
        end else begin
            if (push) begin
                fetch_pc_next = pc_plus4;
                wr_ptr_next   = wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_pc_reg <= RESET_PC;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            entry_reg[wr_ptr_reg] <= {imem_rdata, pc_plus4};
        end
    end

    assign head        = entry_reg[rd_ptr_reg];
    assign out_instr   = out_valid ? head[63:32] : 32'd0;
    assign out_next_pc = out_valid ? head[31:0]  : 32'd0;
    assign imem_addr   = fetch_pc_reg[8:2];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue; instruction memory returns 32'h1000_0000 + word address.
module tb_fetch_queue;

    logic        CLK = 1'b0;
    logic        RST;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [6:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_next_pc;

    int vectors = 0;
    int errors  = 0;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .CLK(CLK),
        .RST(RST),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .stall(stall),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .out_valid(out_valid),
        .out_instr(out_instr),
        .out_next_pc(out_next_pc)
    );

    always #5 CLK = ~CLK;

    assign imem_rdata = 32'h1000_0000 + {25'd0, imem_addr};

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    initial begin
        int exp_idx;
        int mcount;
        int npush;
        logic p_pop;
        logic p_push;

        stall = 1'b0;
        // Reset and stream
        do_reset();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_npc", out_next_pc, 32'd0);
        check("rst_addr", {25'd0, imem_addr}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("stream_valid", {31'd0, out_valid}, 32'd1);
            check("stream_instr", out_instr, 32'h1000_0000 + 32'(k - 1));
            check("stream_npc", out_next_pc, 32'(4 * k));
        end
        $display("stream: 4 instructions checked");

        // Stall fills queue, then drains in order
        stall = 1'b1;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("fill_instr", out_instr, 32'h1000_0000);
            check("fill_addr", {25'd0, imem_addr}, (k >= 4) ? 32'd4 : 32'(k));
        end
        stall = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            tick();
            check("drain_instr", out_instr, 32'h1000_0000 + 32'(j));
            check("drain_addr", {25'd0, imem_addr}, 32'(4 + j));
        end
        $display("fill/drain: full queue hold and ordered drain checked");

        // Redirect flush with 3 queued entries, during stall
        stall = 1'b1;
        do_reset();
        tick(); tick(); tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        stall = 1'b0;
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_addr", {25'd0, imem_addr}, 32'd16);
        tick();
        check("flush_instr0", out_instr, 32'h1000_0010);
        check("flush_npc0", out_next_pc, 32'h44);
        tick();
        check("flush_instr1", out_instr, 32'h1000_0011);
        check("flush_npc1", out_next_pc, 32'h48);
        $display("redirect under stall: flush to 0x40 checked");

        // Redirect while the head would be popped
        do_reset();
        tick(); tick(); tick();
        check("pre_redir_instr", out_instr, 32'h1000_0002);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check("rpop_valid", {31'd0, out_valid}, 32'd0);
        check("rpop_instr", out_instr, 32'd0);
        check("rpop_npc", out_next_pc, 32'd0);
        tick();
        check("rpop_instr0", out_instr, 32'h1000_0010);
        check("rpop_npc0", out_next_pc, 32'h44);
        tick();
        check("rpop_instr1", out_instr, 32'h1000_0011);
        $display("redirect with pop: flush to 0x40 checked");

        // Unaligned target and PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0203;
        tick();
        redirect_valid = 1'b0;
        check("unal_addr", {25'd0, imem_addr}, 32'd0);
        tick();
        check("unal_npc", out_next_pc, 32'h207);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check("wrap_addr", {25'd0, imem_addr}, 32'h7F);
        tick();
        check("wrap_instr", out_instr, 32'h1000_007F);
        check("wrap_npc", out_next_pc, 32'd0);
        tick();
        check("wrap_instr2", out_instr, 32'h1000_0000);
        check("wrap_npc2", out_next_pc, 32'd4);
        $display("unaligned and wrap redirects checked");

        // Pointer wrap: alternating stall with a scoreboard
        stall = 1'b0;
        do_reset();
        exp_idx = 0;
        mcount = 0;
        npush = 0;
        for (int c = 0; c < 20; c++) begin
            stall = (c % 2 == 0);
            p_pop  = (mcount != 0) && !stall;
            p_push = (mcount < 4) || p_pop;
            tick();
            mcount = mcount + (p_push ? 1 : 0) - (p_pop ? 1 : 0);
            npush  = npush + (p_push ? 1 : 0);
            exp_idx = exp_idx + (p_pop ? 1 : 0);
            check("alt_valid", {31'd0, out_valid}, (mcount != 0) ? 32'd1 : 32'd0);
            check("alt_instr", out_instr, 32'h1000_0000 + 32'(exp_idx));
            check("alt_npc", out_next_pc, 32'(4 * (exp_idx + 1)));
            check("alt_addr", {25'd0, imem_addr}, 32'(npush % 128));
        end
        $display("alternating stall: 20 cycles checked, consumed %0d", exp_idx);

        // Reset together with redirect while full
        stall = 1'b1;
        do_reset();
        for (int k = 0; k < 5; k++) tick();
        RST = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        tick();
        RST = 1'b0;
        redirect_valid = 1'b0;
        stall = 1'b0;
        check("mrst_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_addr", {25'd0, imem_addr}, 32'd0);
        tick();
        check("mrst_instr", out_instr, 32'h1000_0000);
        check("mrst_npc", out_next_pc, 32'd4);
        tick();
        check("mrst_instr1", out_instr, 32'h1000_0001);
        $display("reset with redirect: restart at imem[0] checked");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
